// File: rtl/note_pkg.sv
// Shared types and constants for the note sequencer and its song ROM.
package note_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LIVE, ST_FETCH, ST_NOTE, ST_GAP} state_t;

  localparam logic [7:0] NOTE_SILENCE = 8'h00;
  localparam logic [7:0] PS2_BREAK    = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] dur;
  } rom_entry_t;
endpackage

// File: rtl/song_rom.sv
// Combinational song table; dur=0 terminates the song. FILL_ALL gives a
// full-length table (every entry playable) used to exercise index wrap.
module song_rom import note_pkg::*; #(
  parameter int IDX_W    = 5,
  parameter bit FILL_ALL = 1'b0
) (
  input  logic [IDX_W-1:0] idx,
  output rom_entry_t       entry
);
  always_comb begin
    entry = '{code: NOTE_SILENCE, dur: 8'd0};
    if (FILL_ALL) begin
      entry = '{code: 8'h30 + 8'(idx), dur: 8'd2};
    end else begin
      case (idx)
        IDX_W'(0): entry = '{code: 8'h15, dur: 8'd4};
        IDX_W'(1): entry = '{code: 8'h1D, dur: 8'd2};
        default:   ;
      endcase
    end
  end
endmodule

// File: rtl/note_sequencer.sv
// Arbitrates live PS/2 key presses and ROM song playback into a timed
// note/silence stream for the tone generator.
module note_sequencer import note_pkg::*; #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 100,
  parameter int SONG_LEN        = 32,
  parameter int GAP_TICKS       = 3,
  parameter int LIVE_HOLD_TICKS = 50,
  parameter bit ROM_FILL_ALL    = 1'b0,
  localparam int IDX_W = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       key_code,
  input  logic             key_valid,
  input  logic             play_req,
  input  logic             stop_req,
  output logic [7:0]       note_code,
  output logic             note_on,
  output logic             busy,
  output logic [IDX_W-1:0] song_idx
);
  localparam int DIV = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          play_q, stop_q, play_edge, stop_edge;
  logic          brk, brk_n, press, advance;
  logic [7:0]    cnt, cnt_n, note_n;
  logic [IDX_W-1:0] idx_n;
  state_t        state, state_n;
  rom_entry_t    rom;

  assign tick      = (presc == PW'(DIV - 1));
  assign play_edge = play_req & ~play_q;
  assign stop_edge = stop_req & ~stop_q;
  assign press     = key_valid && (key_code != PS2_BREAK) && !brk;
  assign busy      = (state != ST_IDLE);

  song_rom #(.IDX_W(IDX_W), .FILL_ALL(ROM_FILL_ALL)) u_rom (.idx(song_idx), .entry(rom));

  always_comb begin
    state_n = state;
    note_n  = note_code;
    idx_n   = song_idx;
    cnt_n   = cnt;
    brk_n   = brk;
    advance = 1'b0;
    // A break prefix arms the flag; whatever byte follows just disarms it.
    if (key_valid) brk_n = (key_code == PS2_BREAK);

    if (stop_edge) begin
      state_n = ST_IDLE; note_n = NOTE_SILENCE; idx_n = '0; cnt_n = '0;
    end else if (press) begin
      state_n = ST_LIVE; note_n = key_code; idx_n = '0; cnt_n = 8'(LIVE_HOLD_TICKS);
    end else if (play_edge) begin
      state_n = ST_FETCH; note_n = NOTE_SILENCE; idx_n = '0; cnt_n = '0;
    end else begin
      case (state)
        ST_LIVE: if (tick) begin
          if (cnt <= 8'd1) begin
            state_n = ST_IDLE; note_n = NOTE_SILENCE; cnt_n = '0;
          end else cnt_n = cnt - 8'd1;
        end
        ST_FETCH: begin
          if (rom.dur == 8'd0) begin
            state_n = ST_IDLE; idx_n = '0;
          end else begin
            state_n = ST_NOTE; note_n = rom.code; cnt_n = rom.dur;
          end
        end
        ST_NOTE: if (tick) begin
          if (cnt <= 8'd1) begin
            note_n = NOTE_SILENCE;
            if (GAP_TICKS == 0) advance = 1'b1;
            else begin
              state_n = ST_GAP; cnt_n = 8'(GAP_TICKS);
            end
          end else cnt_n = cnt - 8'd1;
        end
        ST_GAP: if (tick) begin
          if (cnt <= 8'd1) advance = 1'b1;
          else cnt_n = cnt - 8'd1;
        end
        default: ;
      endcase
    end

    // Last entry finished: stop rather than replay from the top.
    if (advance) begin
      cnt_n = '0;
      if (song_idx == IDX_W'(SONG_LEN - 1)) begin
        state_n = ST_IDLE; idx_n = '0;
      end else begin
        state_n = ST_FETCH; idx_n = song_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      play_q    <= 1'b0;
      stop_q    <= 1'b0;
      state     <= ST_IDLE;
      note_code <= NOTE_SILENCE;
      note_on   <= 1'b0;
      song_idx  <= '0;
      cnt       <= '0;
      brk       <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      play_q    <= play_req;
      stop_q    <= stop_req;
      state     <= state_n;
      note_code <= note_n;
      note_on   <= (note_n != NOTE_SILENCE);
      song_idx  <= idx_n;
      cnt       <= cnt_n;
      brk       <= brk_n;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: expected output timeline is planned from tick
// arithmetic and the song table, then compared every cycle.
module tb_note_sequencer;
  localparam int DIV = 10;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] key_code = 8'h00, key_code2 = 8'h00;
  logic key_valid = 1'b0, play_req = 1'b0, stop_req = 1'b0;
  logic key_valid2 = 1'b0, play2 = 1'b0, stop2 = 1'b0;
  logic [7:0] note_code, note_code2;
  logic note_on, note_on2, busy, busy2;
  logic [4:0] song_idx;
  logic [1:0] song_idx2;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {int start; int code; int busy; int idx;} seg_t;
  seg_t q1[$], q2[$];

  note_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .SONG_LEN(32), .GAP_TICKS(3),
                   .LIVE_HOLD_TICKS(50), .ROM_FILL_ALL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .play_req(play_req), .stop_req(stop_req), .note_code(note_code),
    .note_on(note_on), .busy(busy), .song_idx(song_idx));

  note_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .SONG_LEN(4), .GAP_TICKS(1),
                   .LIVE_HOLD_TICKS(50), .ROM_FILL_ALL(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_code(key_code2), .key_valid(key_valid2),
    .play_req(play2), .stop_req(stop2), .note_code(note_code2),
    .note_on(note_on2), .busy(busy2), .song_idx(song_idx2));

  always #5 clk = ~clk;

  // Clock edges since reset release; tick-driven changes land on multiples of DIV.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  function automatic int nth_tick(int e, int n);
    return (e / DIV + 1) * DIV + (n - 1) * DIV;
  endfunction

  function automatic int rom_code(int w, int i);
    if (w == 2) return 8'h30 + i;
    if (i == 0) return 8'h15;
    if (i == 1) return 8'h1D;
    return 0;
  endfunction

  function automatic int rom_dur(int w, int i);
    if (w == 2) return 2;
    if (i == 0) return 4;
    if (i == 1) return 2;
    return 0;
  endfunction

  // New segment overrides anything planned from its start onward.
  task automatic add_seg(int w, int s, int c, int b, int i);
    seg_t sg;
    sg.start = s; sg.code = c; sg.busy = b; sg.idx = i;
    if (w == 1) begin
      while (q1.size() > 0 && q1[$].start >= s) void'(q1.pop_back());
      q1.push_back(sg);
    end else begin
      while (q2.size() > 0 && q2[$].start >= s) void'(q2.pop_back());
      q2.push_back(sg);
    end
  endtask

  task automatic plan_song(int w, int e, int gap, int slen);
    int t, d;
    t = e;
    add_seg(w, t, 0, 1, 0);
    for (int i = 0; i < slen; i++) begin
      d = rom_dur(w, i);
      if (d == 0) begin add_seg(w, t + 1, 0, 0, 0); return; end
      add_seg(w, t + 1, rom_code(w, i), 1, i);
      t = nth_tick(t + 1, d);
      if (gap > 0) begin add_seg(w, t, 0, 1, i); t = nth_tick(t, gap); end
      if (i == slen - 1) begin add_seg(w, t, 0, 0, 0); return; end
      add_seg(w, t, 0, 1, i + 1);
    end
  endtask

  function automatic seg_t cur(int w);
    seg_t r;
    r.start = 0; r.code = 0; r.busy = 0; r.idx = 0;
    if (w == 1) begin foreach (q1[k]) if (q1[k].start <= cyc) r = q1[k]; end
    else begin foreach (q2[k]) if (q2[k].start <= cyc) r = q2[k]; end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    seg_t e1, e2;
    e1 = cur(1); e2 = cur(2);
    chk("note_code", note_code, e1.code);
    chk("note_on",   note_on,   e1.code != 0);
    chk("busy",      busy,      e1.busy);
    chk("song_idx",  song_idx,  e1.idx);
    chk("note_code2", note_code2, e2.code);
    chk("note_on2",   note_on2,   e2.code != 0);
    chk("busy2",      busy2,      e2.busy);
    chk("song_idx2",  song_idx2,  e2.idx);
  endtask

  task automatic run(int n);
    repeat (n) begin @(posedge clk); #1; check_all(); end
  endtask

  task automatic pulse_key(logic [7:0] c);
    key_code = c; key_valid = 1'b1; run(1); key_valid = 1'b0;
  endtask

  task automatic pulse_play();
    play_req = 1'b1; run(1); play_req = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_req = 1'b1; run(1); stop_req = 1'b0;
  endtask

  initial begin
    int e, r;
    logic [7:0] c;
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;
    run(5);

    // Stop edge while idle does nothing.
    pulse_stop(); run(3);

    // Live press, repress between hold ticks 30 and 31, silence 50 ticks later.
    run($urandom_range(0, DIV - 1));
    c = 8'($urandom_range(1, 8'hEF));
    e = cyc + 1;
    add_seg(1, e, c, 1, 0); add_seg(1, nth_tick(e, 50), 0, 0, 0);
    pulse_key(c);
    r = nth_tick(e, 30) + $urandom_range(1, DIV - 1);
    run(r - 1 - cyc);
    c = 8'($urandom_range(1, 8'hEF));
    add_seg(1, r, c, 1, 0); add_seg(1, nth_tick(r, 50), 0, 0, 0);
    pulse_key(c);
    run(nth_tick(r, 50) - cyc + 5);

    // Break prefix swallows the next byte; later press sounds; stop ends it.
    run($urandom_range(0, DIV - 1));
    pulse_key(8'hF0); run(2); pulse_key(8'h15); run(3);
    e = cyc + 1;
    add_seg(1, e, 8'h1D, 1, 0); add_seg(1, nth_tick(e, 50), 0, 0, 0);
    pulse_key(8'h1D); run(5);
    add_seg(1, cyc + 1, 0, 0, 0);
    pulse_stop(); run(3);

    // Full song playback to end-of-song marker.
    run($urandom_range(0, DIV - 1));
    plan_song(1, cyc + 1, 3, 32);
    pulse_play();
    run(q1[$].start - cyc + 5);

    // Live press preempts a playing note.
    plan_song(1, cyc + 1, 3, 32);
    pulse_play();
    run($urandom_range(2, 25));
    e = cyc + 1;
    add_seg(1, e, 8'h24, 1, 0); add_seg(1, nth_tick(e, 50), 0, 0, 0);
    pulse_key(8'h24); run(20);
    add_seg(1, cyc + 1, 0, 0, 0);
    pulse_stop(); run(2);

    // Stop and press in the same cycle: stop wins.
    plan_song(1, cyc + 1, 3, 32);
    pulse_play();
    run($urandom_range(2, 60));
    add_seg(1, cyc + 1, 0, 0, 0);
    key_code = 8'h24; key_valid = 1'b1; stop_req = 1'b1;
    run(1);
    key_valid = 1'b0; stop_req = 1'b0;
    run(20);

    // Play edge mid-song restarts from entry 0.
    plan_song(1, cyc + 1, 3, 32);
    pulse_play();
    run($urandom_range(40, 70));
    plan_song(1, cyc + 1, 3, 32);
    pulse_play();
    run(q1[$].start - cyc + 5);

    // Full-length table wraps to idle without replay.
    run($urandom_range(0, DIV - 1));
    plan_song(2, cyc + 1, 1, 4);
    play2 = 1'b1; run(1); play2 = 1'b0;
    run(q2[$].start - cyc + 60);

    // Asynchronous reset in the middle of a note.
    plan_song(1, cyc + 1, 3, 32);
    pulse_play();
    run($urandom_range(3, 20));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_note_code", note_code, 0);
    chk("rst_note_on",   note_on,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_song_idx",  song_idx,  0);
    q1.delete(); q2.delete();
    run(2);
    rst_n = 1'b1;
    run(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
